// File: rtl/txtsu_pkg.sv
// Shared types for the TX timestamp queue: record layout, FSM states and the
// saturating drop-counter helper.
package txtsu_pkg;

    localparam int c_txtsu_port_w = 5;
    localparam int c_txtsu_fid_w  = 16;
    localparam int c_txtsu_ts_w   = 32;

    typedef struct packed {
        logic [c_txtsu_port_w-1:0] port_id;
        logic [c_txtsu_fid_w-1:0]  fid;
        logic [c_txtsu_ts_w-1:0]   tsval;
    } txtsu_rec_t;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        LOAD    = 2'd1,
        PRESENT = 2'd2,
        GAP     = 2'd3
    } txtsu_state_t;

    // Up to two drops can land in one cycle (full-queue push plus ack timeout).
    function automatic logic [15:0] drop_sat_add(input logic [15:0] cnt, input logic [1:0] inc);
        logic [16:0] sum;
        sum = {1'b0, cnt} + {15'd0, inc};
        if (sum[16]) begin
            return 16'hFFFF;
        end else begin
            return sum[15:0];
        end
    endfunction

endpackage

// File: rtl/txtsu_fifo.sv
// Single-clock record FIFO for the timestamp queue; full/empty derive from the
// registered occupancy so push acceptance never depends on a same-cycle pop.
module txtsu_fifo
    import txtsu_pkg::*;
#(
    parameter int g_depth = 16
) (
    input  logic                     clk_i,
    input  logic                     rst_n_i,
    input  logic                     push_i,
    input  logic                     pop_i,
    input  txtsu_rec_t               wdata_i,
    output txtsu_rec_t               rdata_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(g_depth):0] count_o
);

    localparam int               c_aw      = $clog2(g_depth);
    localparam logic [c_aw:0]    c_full    = (c_aw + 1)'(g_depth);
    localparam logic [c_aw:0]    c_cnt_one = (c_aw + 1)'(1'b1);
    localparam logic [c_aw-1:0]  c_ptr_one = c_aw'(1'b1);

    txtsu_rec_t      mem_q [g_depth];
    logic [c_aw-1:0] wr_ptr_q, wr_ptr_d;
    logic [c_aw-1:0] rd_ptr_q, rd_ptr_d;
    logic [c_aw:0]   count_q, count_d;
    logic            push_ok_s, pop_ok_s;

    assign full_o    = (count_q == c_full);
    assign empty_o   = (count_q == {(c_aw + 1){1'b0}});
    assign push_ok_s = push_i & ~full_o;
    assign pop_ok_s  = pop_i & ~empty_o;
    assign rdata_o   = mem_q[rd_ptr_q];
    assign count_o   = count_q;

    // Next pointers and occupancy; pointers wrap naturally at the power-of-two depth.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_ok_s) begin
            wr_ptr_d = wr_ptr_q + c_ptr_one;
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (pop_ok_s) begin
            rd_ptr_d = rd_ptr_q + c_ptr_one;
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        case ({push_ok_s, pop_ok_s})
            2'b10:   count_d = count_q + c_cnt_one;
            2'b01:   count_d = count_q - c_cnt_one;
            default: count_d = count_q;
        endcase
    end

    // Pointer and occupancy registers.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            wr_ptr_q <= {c_aw{1'b0}};
            rd_ptr_q <= {c_aw{1'b0}};
            count_q  <= {(c_aw + 1){1'b0}};
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage array; contents are don't-care until written, so no reset.
    always_ff @(posedge clk_i) begin
        if (push_ok_s) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end

endmodule

// File: rtl/txtsu_queue.sv
// TX timestamp queue: buffers records and presents them on the valid/ack TXTSU
// interface with drop accounting. Define TXTSU_QUEUE_TIMEOUT_EN for ack timeout.
module txtsu_queue
    import txtsu_pkg::*;
#(
    parameter int g_depth       = 16,
    parameter int g_ack_timeout = 1024
) (
    input  logic                     clk_i,
    input  logic                     rst_n_i,
    input  logic                     ts_valid_i,
    input  logic [4:0]               ts_port_id_i,
    input  logic [15:0]              ts_fid_i,
    input  logic [31:0]              ts_tsval_i,
    output logic [4:0]               txtsu_port_id_o,
    output logic [15:0]              txtsu_fid_o,
    output logic [31:0]              txtsu_tsval_o,
    output logic                     txtsu_valid_o,
    input  logic                     txtsu_ack_i,
    output logic                     overflow_o,
    output logic [15:0]              drop_cnt_o,
    output logic [$clog2(g_depth):0] count_o
);

    localparam int c_cnt_w = $clog2(g_depth) + 1;

    if (g_depth < 2 || (g_depth & (g_depth - 1)) != 0 || g_ack_timeout < 1) begin : g_bad_param
        $error("txtsu_queue: g_depth must be a power of two >= 2 and g_ack_timeout >= 1");
    end

    txtsu_state_t       state_q, state_d;
    txtsu_rec_t         rec_q, rec_d;
    txtsu_rec_t         push_rec_s, fifo_rdata_s;
    logic               valid_q, valid_d;
    logic               overflow_q, overflow_d;
    logic [15:0]        drop_q, drop_d;
    logic               fifo_full_s, fifo_empty_s, fifo_pop_s;
    logic               ovf_drop_s, tmo_drop_s, tmo_expire_s;
    logic [c_cnt_w-1:0] fifo_count_s;

    assign push_rec_s = {ts_port_id_i, ts_fid_i, ts_tsval_i};
    assign fifo_pop_s = (state_q == LOAD);
    assign ovf_drop_s = ts_valid_i & fifo_full_s;

    txtsu_fifo #(
        .g_depth (g_depth)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_n_i (rst_n_i),
        .push_i  (ts_valid_i),
        .pop_i   (fifo_pop_s),
        .wdata_i (push_rec_s),
        .rdata_o (fifo_rdata_s),
        .full_o  (fifo_full_s),
        .empty_o (fifo_empty_s),
        .count_o (fifo_count_s)
    );

`ifdef TXTSU_QUEUE_TIMEOUT_EN
    localparam int c_tmo_w = (g_ack_timeout > 1) ? $clog2(g_ack_timeout) : 1;

    logic [c_tmo_w-1:0] tmo_q, tmo_d;

    assign tmo_expire_s = (state_q == PRESENT) && (tmo_q == c_tmo_w'(g_ack_timeout - 1));

    // Cycles spent in PRESENT; restarts from zero on every new presentation.
    always_comb begin
        tmo_d = {c_tmo_w{1'b0}};
        if (state_q == PRESENT && !txtsu_ack_i && !tmo_expire_s) begin
            tmo_d = tmo_q + c_tmo_w'(1'b1);
        end else begin
            tmo_d = {c_tmo_w{1'b0}};
        end
    end

    // Timeout counter register.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            tmo_q <= {c_tmo_w{1'b0}};
        end else begin
            tmo_q <= tmo_d;
        end
    end
`else
    assign tmo_expire_s = 1'b0;
`endif

    // Presentation FSM; an ack coinciding with expiry is honoured as an ack.
    always_comb begin
        state_d    = state_q;
        valid_d    = valid_q;
        rec_d      = rec_q;
        tmo_drop_s = 1'b0;
        case (state_q)
            IDLE: begin
                if (!fifo_empty_s) begin
                    state_d = LOAD;
                end else begin
                    state_d = IDLE;
                end
            end
            LOAD: begin
                rec_d   = fifo_rdata_s;
                valid_d = 1'b1;
                state_d = PRESENT;
            end
            PRESENT: begin
                if (txtsu_ack_i) begin
                    valid_d = 1'b0;
                    state_d = GAP;
                end else if (tmo_expire_s) begin
                    valid_d    = 1'b0;
                    state_d    = GAP;
                    tmo_drop_s = 1'b1;
                end else begin
                    state_d = PRESENT;
                end
            end
            GAP: begin
                valid_d = 1'b0;
                state_d = IDLE;
            end
            default: begin
                valid_d = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    // Loss accounting.
    always_comb begin
        overflow_d = overflow_q | ovf_drop_s;
        drop_d     = drop_sat_add(drop_q, {1'b0, ovf_drop_s} + {1'b0, tmo_drop_s});
    end

    // Output and FSM state registers.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q    <= IDLE;
            valid_q    <= 1'b0;
            rec_q      <= '{port_id: 5'd0, fid: 16'd0, tsval: 32'd0};
            overflow_q <= 1'b0;
            drop_q     <= 16'd0;
        end else begin
            state_q    <= state_d;
            valid_q    <= valid_d;
            rec_q      <= rec_d;
            overflow_q <= overflow_d;
            drop_q     <= drop_d;
        end
    end

    assign txtsu_port_id_o = rec_q.port_id;
    assign txtsu_fid_o     = rec_q.fid;
    assign txtsu_tsval_o   = rec_q.tsval;
    assign txtsu_valid_o   = valid_q;
    assign overflow_o      = overflow_q;
    assign drop_cnt_o      = drop_q;
    assign count_o         = fifo_count_s;

endmodule

// File: tb/tb_txtsu_queue.sv
// Scoreboard bench for txtsu_queue (depth 4, ack timeout 8).
module tb_txtsu_queue;

    localparam int c_depth = 4;
    localparam int c_tmo   = 8;

    typedef struct packed {
        logic [4:0]  p;
        logic [15:0] f;
        logic [31:0] t;
    } rec_t;

    logic                     clk_i = 1'b0;
    logic                     rst_n_i;
    logic                     ts_valid_i;
    logic [4:0]               ts_port_id_i;
    logic [15:0]              ts_fid_i;
    logic [31:0]              ts_tsval_i;
    logic [4:0]               txtsu_port_id_o;
    logic [15:0]              txtsu_fid_o;
    logic [31:0]              txtsu_tsval_o;
    logic                     txtsu_valid_o;
    logic                     txtsu_ack_i;
    logic                     overflow_o;
    logic [15:0]              drop_cnt_o;
    logic [$clog2(c_depth):0] count_o;

    rec_t exp_q[$];
    rec_t cur_exp;
    int   n_checks    = 0;
    int   n_errors    = 0;
    int   n_presented = 0;
    int   ack_mode    = 0;   // 0 none, 1 ack while valid, 2 constant high
    logic manual_ack  = 1'b0;
    logic prev_valid  = 1'b0;

    txtsu_queue #(
        .g_depth       (c_depth),
        .g_ack_timeout (c_tmo)
    ) dut (
        .clk_i           (clk_i),
        .rst_n_i         (rst_n_i),
        .ts_valid_i      (ts_valid_i),
        .ts_port_id_i    (ts_port_id_i),
        .ts_fid_i        (ts_fid_i),
        .ts_tsval_i      (ts_tsval_i),
        .txtsu_port_id_o (txtsu_port_id_o),
        .txtsu_fid_o     (txtsu_fid_o),
        .txtsu_tsval_o   (txtsu_tsval_o),
        .txtsu_valid_o   (txtsu_valid_o),
        .txtsu_ack_i     (txtsu_ack_i),
        .overflow_o      (overflow_o),
        .drop_cnt_o      (drop_cnt_o),
        .count_o         (count_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic push(input logic [4:0] p, input logic [15:0] f, input logic [31:0] t, input bit acc);
        rec_t r;
        r            = {p, f, t};
        ts_valid_i   = 1'b1;
        ts_port_id_i = p;
        ts_fid_i     = f;
        ts_tsval_i   = t;
        if (acc) exp_q.push_back(r);
        @(negedge clk_i);
        ts_valid_i = 1'b0;
    endtask

    task automatic wait_valid(input logic v, input int max, input string name);
        int k;
        k = 0;
        while (txtsu_valid_o !== v && k < max) begin
            @(negedge clk_i);
            k++;
        end
        if (txtsu_valid_o !== v) begin
            n_checks++;
            n_errors++;
            $display("FAIL %s timeout waiting valid=%0b", name, v);
        end
    endtask

    task automatic drain(input int max, input string name);
        int k;
        k = 0;
        while ((exp_q.size() != 0 || txtsu_valid_o) && k < max) begin
            @(negedge clk_i);
            k++;
        end
        chk(name, exp_q.size(), 0);
    endtask

    // Consumer: ack decided shortly after the falling edge.
    initial begin
        txtsu_ack_i = 1'b0;
        forever begin
            @(negedge clk_i);
            #1;
            txtsu_ack_i = (ack_mode == 2) || (ack_mode == 1 && txtsu_valid_o) || manual_ack;
        end
    end

    // Monitor: each new presentation is checked against the scoreboard head.
    initial begin
        forever begin
            @(negedge clk_i);
            if (!rst_n_i) begin
                prev_valid = 1'b0;
            end else begin
                if (txtsu_valid_o && !prev_valid) begin
                    n_presented++;
                    if (exp_q.size() == 0) begin
                        n_checks++;
                        n_errors++;
                        $display("FAIL unexpected_record actual=%0h required=none", txtsu_fid_o);
                    end else begin
                        cur_exp = exp_q.pop_front();
                        chk("rec_port", txtsu_port_id_o, cur_exp.p);
                        chk("rec_fid", txtsu_fid_o, cur_exp.f);
                        chk("rec_tsval", txtsu_tsval_o, cur_exp.t);
                    end
                end else if (txtsu_valid_o && prev_valid) begin
                    chk("hold_stable", {txtsu_port_id_o, txtsu_fid_o, txtsu_tsval_o}, cur_exp);
                end
                prev_valid = txtsu_valid_o;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int p0;
        int hi;
        rst_n_i      = 1'b0;
        ts_valid_i   = 1'b0;
        ts_port_id_i = 5'd0;
        ts_fid_i     = 16'd0;
        ts_tsval_i   = 32'd0;
        repeat (3) @(negedge clk_i);
        chk("rst_valid", txtsu_valid_o, 1'b0);
        chk("rst_count", count_o, 3'd0);
        chk("rst_drop", drop_cnt_o, 16'd0);
        chk("rst_ovf", overflow_o, 1'b0);
        chk("rst_data", {txtsu_port_id_o, txtsu_fid_o, txtsu_tsval_o}, 53'd0);
        rst_n_i = 1'b1;
        @(negedge clk_i);

        // Single record, latency N+2, ack one cycle after valid.
        ack_mode = 1;
        p0 = n_presented;
        push(5'd3, 16'h1234, 32'hA000_0005, 1'b1);
        chk("single_count_after_push", count_o, 3'd1);
        chk("single_valid_n1", txtsu_valid_o, 1'b0);
        @(negedge clk_i);
        chk("single_valid_n1b", txtsu_valid_o, 1'b0);
        @(negedge clk_i);
        chk("single_valid_n2", txtsu_valid_o, 1'b1);
        chk("single_count_n2", count_o, 3'd0);
        @(negedge clk_i);
        chk("single_valid_gap", txtsu_valid_o, 1'b0);
        repeat (3) @(negedge clk_i);
        chk("single_hold_fid", txtsu_fid_o, 16'h1234);
        chk("single_presented", n_presented - p0, 1);

        // Burst of 5 with ack held high.
        ack_mode = 2;
        p0 = n_presented;
        for (int i = 0; i < 5; i++) begin
            push(5'(i + 1), 16'h0101 + 16'(i), 32'h1000_0000 + 32'(i), 1'b1);
        end
        drain(100, "burst_drain");
        ack_mode = 0;
        chk("burst_presented", n_presented - p0, 5);
        chk("burst_drop", drop_cnt_o, 16'd0);
        chk("burst_ovf", overflow_o, 1'b0);
        chk("burst_count", count_o, 3'd0);

        // Overflow: 7 pushes with ack stalled, last two dropped.
        @(negedge clk_i);
        p0 = n_presented;
        for (int i = 0; i < 7; i++) begin
            push(5'd7, 16'h0201 + 16'(i), 32'h2000_0000 + 32'(i), i < 5);
        end
        chk("ovf_drop", drop_cnt_o, 16'd2);
        chk("ovf_flag", overflow_o, 1'b1);
        chk("ovf_count", count_o, 3'd4);
        chk("ovf_valid", txtsu_valid_o, 1'b1);
        ack_mode = 1;
        drain(100, "ovf_drain");
        ack_mode = 0;
        chk("ovf_presented", n_presented - p0, 5);

        // Full queue with push landing on the LOAD cycle.
        @(negedge clk_i);
        p0 = n_presented;
        for (int i = 0; i < 5; i++) begin
            push(5'd9, 16'h0301 + 16'(i), 32'h3000_0000 + 32'(i), 1'b1);
        end
        chk("coll_count_full", count_o, 3'd4);
        manual_ack = 1'b1;
        @(negedge clk_i);
        manual_ack = 1'b0;
        @(negedge clk_i);
        @(negedge clk_i);
        push(5'd9, 16'h0306, 32'h3000_0005, 1'b0);
        chk("coll_drop", drop_cnt_o, 16'd3);
        chk("coll_count", count_o, 3'd3);
        ack_mode = 1;
        drain(100, "coll_drain");
        ack_mode = 0;
        chk("coll_presented", n_presented - p0, 5);
        chk("coll_ovf_sticky", overflow_o, 1'b1);

        // Asynchronous reset while presenting with 3 queued.
        @(negedge clk_i);
        for (int i = 0; i < 4; i++) begin
            push(5'd11, 16'h0501 + 16'(i), 32'h5000_0000 + 32'(i), 1'b1);
        end
        chk("rstmid_count", count_o, 3'd3);
        chk("rstmid_valid", txtsu_valid_o, 1'b1);
        #2;
        rst_n_i = 1'b0;
        #1;
        chk("rstmid_valid_async", txtsu_valid_o, 1'b0);
        chk("rstmid_count_async", count_o, 3'd0);
        chk("rstmid_drop_async", drop_cnt_o, 16'd0);
        chk("rstmid_ovf_async", overflow_o, 1'b0);
        exp_q.delete();
        @(negedge clk_i);
        rst_n_i = 1'b1;
        @(negedge clk_i);
        ack_mode = 1;
        p0 = n_presented;
        push(5'd12, 16'h0510, 32'h5100_0000, 1'b1);
        drain(50, "rstmid_drain");
        ack_mode = 0;
        chk("rstmid_presented", n_presented - p0, 1);
        chk("rstmid_count_end", count_o, 3'd0);

`ifdef TXTSU_QUEUE_TIMEOUT_EN
        // Timeout after 8 PRESENT cycles, then ack exactly on expiry.
        @(negedge clk_i);
        p0 = n_presented;
        push(5'd13, 16'h0601, 32'h6000_0001, 1'b1);
        push(5'd13, 16'h0602, 32'h6000_0002, 1'b1);
        wait_valid(1'b1, 10, "tmo_first_valid");
        hi = 0;
        while (txtsu_valid_o && hi < 20) begin
            hi++;
            @(negedge clk_i);
        end
        chk("tmo_cycles", hi, 8);
        chk("tmo_drop", drop_cnt_o, 16'd1);
        wait_valid(1'b1, 10, "tmo_second_valid");
        repeat (7) @(negedge clk_i);
        manual_ack = 1'b1;
        @(negedge clk_i);
        manual_ack = 1'b0;
        chk("tmo_ack_valid", txtsu_valid_o, 1'b0);
        repeat (3) @(negedge clk_i);
        chk("tmo_ack_nodrop", drop_cnt_o, 16'd1);
        chk("tmo_presented", n_presented - p0, 2);
        chk("tmo_sb_empty", exp_q.size(), 0);
`else
        // Without the timeout feature PRESENT waits indefinitely.
        @(negedge clk_i);
        push(5'd13, 16'h0601, 32'h6000_0001, 1'b1);
        wait_valid(1'b1, 10, "notmo_valid");
        repeat (20) @(negedge clk_i);
        chk("notmo_still_valid", txtsu_valid_o, 1'b1);
        chk("notmo_drop", drop_cnt_o, 16'd0);
        ack_mode = 1;
        drain(20, "notmo_drain");
        ack_mode = 0;
`endif

        repeat (2) @(negedge clk_i);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
